// File: rtl/demux2b_1u2_buffered.sv
// 1-to-2 demultiplexer for a WIDTH-bit stream: each accepted beat is routed by in_sel
// into a per-channel FIFO with its own valid/ready handshake and delivered-beat counter.
module demux2b_1u2_buffered #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [1:0]       out_ready_v;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [WIDTH-1:0] head  [2];
    logic [CNT_W-1:0] cnt_v [2];

    assign out_ready_v = {out1_ready, out0_ready};

    // Input readiness looks only at the selected FIFO's full flag, so a same-cycle
    // pop never opens the input and there is no path from out*_ready to in_ready.
    assign in_ready = rst_n & ~full[in_sel];

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W:0]   occ;
        logic [CNT_W-1:0] cnt;

        assign full[k]  = (occ == OCC_FULL);
        assign empty[k] = (occ == '0);
        assign push[k]  = in_valid & in_ready & (in_sel == 1'(k));
        assign pop[k]   = ~empty[k] & out_ready_v[k];
        assign head[k]  = empty[k] ? '0 : mem[rd_ptr];
        assign cnt_v[k] = cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt    <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    cnt    <= cnt + 1'b1;
                end
                if (push[k] && !pop[k]) begin
                    occ <= occ + 1'b1;
                end else if (!push[k] && pop[k]) begin
                    occ <= occ - 1'b1;
                end
            end
        end

        // Storage needs no reset: head data is masked to zero whenever the FIFO is empty.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign cnt0       = cnt_v[0];
    assign cnt1       = cnt_v[1];

endmodule

// File: tb/tb_demux2b_1u2_buffered.sv
// Bench for demux2b_1u2_buffered: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_demux2b_1u2_buffered;
    localparam int WIDTH = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always #5 clk = ~clk;

    demux2b_1u2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  rand_rdy = 1'b0;
    bit  acc;

    // Reference model: expected contents of each channel and beats delivered so far.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int pc0 = 0;
    int pc1 = 0;
    int sz_sel;
    logic [WIDTH-1:0] h0, h1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            sz_sel = in_sel ? q1.size() : q0.size();
            h0 = (q0.size() != 0) ? q0[0] : '0;
            h1 = (q1.size() != 0) ? q1[0] : '0;
            chk("in_ready", 32'(in_ready), 32'(rst_n && (sz_sel < DEPTH)));
            chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            chk("out0_data", 32'(out0_data), 32'(h0));
            chk("out1_data", 32'(out1_data), 32'(h1));
            chk("cnt0", 32'(cnt0), 32'(pc0 % (1 << CNT_W)));
            chk("cnt1", 32'(cnt1), 32'(pc1 % (1 << CNT_W)));
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                pc0 = 0;
                pc1 = 0;
            end else begin
                if (q0.size() != 0 && out0_ready) begin
                    void'(q0.pop_front());
                    pc0++;
                end
                if (q1.size() != 0 && out1_ready) begin
                    void'(q1.pop_front());
                    pc1++;
                end
            end
        end
    end

    // One clock: note acceptance at negedge, record it at the edge, return 1 after the edge.
    task automatic cycle(output bit a);
        @(negedge clk);
        a = in_valid && in_ready;
        @(posedge clk);
        if (a) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        #1;
        if (rand_rdy) begin
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive(input logic s, input logic [WIDTH-1:0] d);
        int  n = 0;
        bit  a = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        while (!a && n < 50) begin
            cycle(a);
            n++;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: beat %0h sel %0d not accepted within %0d cycles", d, s, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) cycle(a);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // reset then idle
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'({out0_valid, out1_valid}), 0);
        cycle(acc);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 1);
        idle(2);
        chk("idle_cnt", 32'({cnt0, cnt1}), 0);

        // routing and latency
        out0_ready = 1'b1; out1_ready = 1'b1;
        drive(1'b0, 2'b01);
        chk("lat_valid0", 32'(out0_valid), 1);
        chk("lat_data0", 32'(out0_data), 32'h1);
        drive(1'b1, 2'b10);
        chk("lat_data1", 32'(out1_data), 32'h2);
        drive(1'b0, 2'b11);
        idle(3);
        chk("route_cnt0", 32'(cnt0), 2);
        chk("route_cnt1", 32'(cnt1), 1);

        // backpressure and full
        out0_ready = 1'b0; out1_ready = 1'b0;
        drive(1'b0, 2'b00);
        drive(1'b0, 2'b01);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b10;
        #1 chk("full_blocks", 32'(in_ready), 0);
        cycle(acc);
        chk("full_not_accepted", 32'(acc), 0);
        in_valid = 1'b0; in_sel = 1'b1;
        #1 chk("other_ch_ready", 32'(in_ready), 1);
        drive(1'b1, 2'b00);
        out0_ready = 1'b1;
        drive(1'b0, 2'b10);
        idle(4);
        chk("bp_cnt0_wrapped", 32'(cnt0), 1);

        // simultaneous push and pop on channel 1
        out1_ready = 1'b1;
        idle(2);
        out1_ready = 1'b0;
        drive(1'b1, 2'b11);
        chk("sim_pre_data", 32'(out1_data), 32'h3);
        out1_ready = 1'b1;
        drive(1'b1, 2'b01);
        out1_ready = 1'b0;
        chk("sim_valid", 32'(out1_valid), 1);
        chk("sim_new_head", 32'(out1_data), 32'h1);
        chk("sim_cnt1", 32'(cnt1), 3);
        out1_ready = 1'b1;
        idle(1);
        chk("sim_occ_one", 32'(out1_valid), 0);

        // reset mid-operation
        out0_ready = 1'b0; out1_ready = 1'b0;
        drive(1'b0, 2'b01);
        drive(1'b0, 2'b10);
        drive(1'b1, 2'b11);
        drive(1'b1, 2'b00);
        rst_n = 1'b0;
        cycle(acc);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'({out0_valid, out1_valid}), 0);
        out0_ready = 1'b1; out1_ready = 1'b1;
        idle(3);
        chk("mid_rst_cnt", 32'({cnt0, cnt1}), 0);
        chk("mid_rst_valid_after", 32'({out0_valid, out1_valid}), 0);

        // counter wrap on channel 0: first beat after reset is the first delivered
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, WIDTH'(i));
            idle(1);
            chk("wrap_cnt0", 32'(cnt0), 32'(i % 4));
            chk("wrap_cnt1", 32'(cnt1), 0);
        end

        // random traffic
        rand_rdy = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 3)));
        end
        rand_rdy = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        idle(4);
        chk("drained", 32'({out0_valid, out1_valid}), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux2b_1u2_buffered.md
Name: demux2b_1u2_buffered

Overview:
- 1-to-2 demultiplexer for a 2-bit data stream; the inverse direction of the team's 2-bit 2:1 mux.
- Each accepted input beat is routed by `in_sel` to one of two output channels.
- Each output channel has its own small FIFO and a valid/ready handshake, so one stalled consumer does not lose data.
- Sits between a single producer and two independent consumers in the lab combinational/sequential component set.

Parameters:
- WIDTH, 2, data width of every beat.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CNT_W, 8, width of each per-channel delivered-beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_data  input  WIDTH  input beat.
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block can accept a beat for the currently selected channel.
- out0_data  output  WIDTH  channel 0 head-of-FIFO data.
- out0_valid  output  1  channel 0 FIFO non-empty.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 head-of-FIFO data.
- out1_valid  output  1  channel 1 FIFO non-empty.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  beats delivered on channel 0.
- cnt1  output  CNT_W  beats delivered on channel 1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Both FIFOs are emptied; read/write pointers and occupancy go to 0.
  - out0_valid=0, out1_valid=0, cnt0=0, cnt1=0.
  - out0_data and out1_data are driven to 0.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards all buffered beats; nothing is delivered after reset until a new beat is accepted.
- Input handshake:
  - A beat is accepted at an edge where in_valid=1 and in_ready=1.
  - in_ready = rst_n & !full[in_sel]. It is combinational on in_sel and FIFO full flags only, never on out*_ready; there is no comb path from output ready to input ready.
  - A full destination FIFO blocks input even if the same-cycle pop would free a slot.
  - The other channel's fullness is irrelevant.
  - in_sel, in_data and in_valid must stay stable while in_valid=1 and in_ready=0. The producer may change in_sel only after acceptance or with in_valid=0.
- Output handshake (per channel k):
  - outk_valid = FIFO k non-empty. outk_data = FIFO k head, registered storage, held stable while outk_valid=1 and outk_ready=0.
  - A pop occurs at an edge with outk_valid=1 and outk_ready=1.
  - outk_ready while outk_valid=0 has no effect.
- Latency: a beat accepted at edge N appears on outk_valid/outk_data after edge N, i.e. visible in cycle N+1, if FIFO k was empty. Otherwise it appears behind older beats.
- Ordering: strict FIFO order within a channel; no ordering relation between channels.
- Simultaneous push and pop on the same FIFO:
  - Both take effect.
  - Occupancy is unchanged.
  - When occupancy was 1, the new beat becomes head the following cycle.
- Full/empty:
  - Occupancy is tracked 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - Full when occupancy=DEPTH; empty when occupancy=0.
  - Overflow and underflow are impossible by construction.
- Counters:
  - cntk increments by 1 on every channel-k pop.
  - Wraps from 2^CNT_W-1 to 0; no saturation.
  - Registered; updates on the same edge as the pop.
- No FSM beyond the per-channel FIFO occupancy; the block is fully pipelined, with 1 beat per cycle peak throughput.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 2 cycles, release with in_valid=0.
  - Response: in_ready=0 during reset, then 1; out0_valid=out1_valid=0; cnt0=cnt1=0.
- Routing and latency:
  - Stimulus: both readys=1; send data 2'b01 sel=0, then 2'b10 sel=1, then 2'b11 sel=0 on consecutive edges.
  - Response: out0 shows 01 then 11; out1 shows 10; each appears one cycle after acceptance; cnt0=2, cnt1=1.
- Backpressure and full, DEPTH=2:
  - Stimulus: out0_ready=0; send 00, 01, 10 to sel=0.
  - Response: first two accepted, in_ready=0 for the third.
  - Stimulus: switch to sel=1.
  - Response: in_ready=1 and channel 1 accepts.
  - Stimulus: raise out0_ready.
  - Response: 00, 01 delivered in order, then 10 accepted.
- Simultaneous push/pop:
  - Stimulus: channel 1 holds one beat 11, out1_ready=1; push 01 to sel=1 on the same edge.
  - Response: 11 popped, 01 valid next cycle; occupancy stays 1; cnt1 increments by 1.
- Counter wrap, CNT_W=2:
  - Stimulus: deliver 5 beats on channel 0.
  - Response: cnt0 sequence 1,2,3,0,1; cnt1 stays 0.
- Reset mid-operation:
  - Stimulus: fill both FIFOs with out*_ready=0; pulse rst_n=0 for 1 cycle; then set out*_ready=1.
  - Response: no beats delivered; out*_valid=0; counters=0; the next accepted beat is the first delivered.
